// File: rtl/bist_alu.sv
// ---------------------------------------------------------------------------
// bist_alu -- self-testing 8-bit ALU wrapper
//
// After reset is released, an on-chip 16-bit LFSR drives operand patterns into
// the ALU under test (CUT). A 16-bit MISR compacts the CUT results. A second
// MISR compacts the results of an independently coded reference ALU. After
// NUM_PATTERNS patterns the two signatures are compared.
//
// Ports:
//   clk            in   single clock, all state updates on the rising edge
//   reset          in   synchronous, active-low reset
//   FAULT_DETECTED out  1 = CUT signature differs from reference signature
//                       (valid once bist_done=1)
//   bist_done      out  1 = test sequence complete, held until reset
//
// Parameters:
//   WIDTH        operand width (2*WIDTH must fit the 16-bit LFSR; 8 nominal)
//   NUM_PATTERNS patterns applied in RUN, 8..65535
//   LFSR_SEED    nonzero LFSR reset value
//   MISR_SEED    reset value of both MISRs
//   FAULT_BIT    CUT result bit forced stuck-at-0 under fault injection
//
// Optional feature: define BIST_ALU_FAULT_INJECT_EN to force CUT result bit
// FAULT_BIT to 0. The reference ALU is never affected.
//
// Also contains the two ALU implementations:
//   bist_alu_cut  structural-style ALU (circuit under test)
//   bist_alu_ref  behavioural reference ALU
// Both take a, b [WIDTH-1:0] and op [2:0] and return res = {carry, result}.
// ---------------------------------------------------------------------------

// Circuit under test. Subtraction is built as an adder with inverted B and a
// carry-in of 1, so the borrow is the inverted carry-out.
module bist_alu_cut #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH:0]   res
);

    logic [WIDTH:0] diff;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        res  = '0;
        diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        unique case (op)
            3'd0: res = {1'b0, a} + {1'b0, b};                 // ADD
            3'd1: res = {~diff[WIDTH], diff[WIDTH-1:0]};       // SUB, borrow
            3'd2: res = {1'b0, a & b};                         // AND
            3'd3: res = {1'b0, a | b};                         // OR
            3'd4: res = {1'b0, a ^ b};                         // XOR
            3'd5: res = {1'b0, ~a};                            // NOT A
            3'd6: res = {a, 1'b0};                             // SHL, carry=A msb
            3'd7: res = {a[0], 1'b0, a[WIDTH-1:1]};            // SHR, carry=A lsb
            default: res = '0;
        endcase
    end

endmodule

// Reference ALU, deliberately written with different arithmetic idioms from
// the CUT so the two never collapse into shared logic.
module bist_alu_ref #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH:0]   res
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    logic [WIDTH-1:0] ones;

    always_comb begin
        res  = '0;
        ones = '1;
        case (op)
            OP_ADD:  res = (WIDTH+1)'(a) + (WIDTH+1)'(b);
            OP_SUB:  res = {(a < b), WIDTH'(a - b)};
            OP_AND:  res = (WIDTH+1)'(a & b);
            OP_OR:   res = (WIDTH+1)'(a | b);
            OP_XOR:  res = (WIDTH+1)'(a ^ b);
            OP_NOT:  res = (WIDTH+1)'(a ^ ones);
            OP_SHL:  res = (WIDTH+1)'(a) << 1;
            OP_SHR:  res = {a[0], a >> 1};
            default: res = '0;
        endcase
    end

endmodule

module bist_alu #(
    parameter int          WIDTH        = 8,
    parameter int          NUM_PATTERNS = 128,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [15:0] MISR_SEED    = 16'h0000,
    parameter int          FAULT_BIT    = 0
) (
    input  logic clk,
    input  logic reset,
    output logic FAULT_DETECTED,
    output logic bist_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] LAST_PATTERN = 16'(NUM_PATTERNS - 1);

    state_t         state;
    state_t         state_next;
    logic           armed;        // IDLE has been held for its one cycle
    logic [15:0]    lfsr;
    logic [15:0]    counter;
    logic [15:0]    cut_misr;
    logic [15:0]    ref_misr;
    logic           fault;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_sel;

    (* keep *) logic [WIDTH:0] cut_raw;
    (* keep *) logic [WIDTH:0] ref_res;
    logic [WIDTH:0]            cut_res;

    // x^16 + x^14 + x^13 + x^11 + 1, shared by the LFSR and both MISRs
    function automatic logic poly_fb(input logic [15:0] v);
        return v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m,
                                              input logic [WIDTH:0] r);
        return {m[14:0], poly_fb(m)} ^ 16'(r);
    endfunction

    // Pattern mapping: operands from the LFSR, opcode from the counter so
    // every opcode is applied equally often.
    assign op_a   = lfsr[WIDTH-1:0];
    assign op_b   = lfsr[2*WIDTH-1:WIDTH];
    assign op_sel = counter[2:0];

    (* keep_hierarchy = "yes" *)
    bist_alu_cut #(.WIDTH(WIDTH)) u_cut (
        .a   (op_a),
        .b   (op_b),
        .op  (op_sel),
        .res (cut_raw)
    );

    (* keep_hierarchy = "yes" *)
    bist_alu_ref #(.WIDTH(WIDTH)) u_ref (
        .a   (op_a),
        .b   (op_b),
        .op  (op_sel),
        .res (ref_res)
    );

`ifdef BIST_ALU_FAULT_INJECT_EN
    // Stuck-at-0 on one CUT result bit; the reference path stays clean.
    always_comb begin
        cut_res            = cut_raw;
        cut_res[FAULT_BIT] = 1'b0;
    end
`else
    assign cut_res = cut_raw;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (armed) state_next = RUN;
            RUN:     if (counter == LAST_PATTERN) state_next = COMPARE;
            COMPARE: state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            lfsr     <= LFSR_SEED;
            counter  <= '0;
            cut_misr <= MISR_SEED;
            ref_misr <= MISR_SEED;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                armed <= 1'b1;
            end
            if (state == RUN) begin
                lfsr     <= {lfsr[14:0], poly_fb(lfsr)};
                counter  <= counter + 16'd1;
                cut_misr <= misr_step(cut_misr, cut_res);
                ref_misr <= misr_step(ref_misr, ref_res);
            end
            if (state == COMPARE) begin
                fault <= (cut_misr != ref_misr);
            end
        end
    end

    assign FAULT_DETECTED = fault;
    assign bist_done      = (state == DONE);

endmodule

// File: tb/tb_bist_alu.sv
// ---------------------------------------------------------------------------
// tb_bist_alu -- self-checking bench for bist_alu
//
// Runs a 128-pattern instance and an 8-pattern instance from a shared reset,
// checks output timing every cycle, checks final LFSR/signature values against
// a behavioural model, checks the DONE freeze, a randomly timed reset abort,
// and unit-checks both ALU implementations with directed and random vectors.
// ---------------------------------------------------------------------------
module tb_bist_alu;

    localparam int          N_MAIN    = 128;
    localparam int          N_SHORT   = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] MISR_SEED = 16'h0000;
    localparam int          FAULT_BIT = 0;

    logic clk;
    logic reset;
    logic fd_main, done_main;
    logic fd_short, done_short;

    logic [7:0] ua, ub;
    logic [2:0] uop;
    logic [8:0] ucut, uref;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr_main, m_cut_main, m_ref_main;
    logic [15:0] m_lfsr_short, m_cut_short, m_ref_short;
    logic        exp_fault_main, exp_fault_short;

    bist_alu #(.NUM_PATTERNS(N_MAIN)) dut (
        .clk            (clk),
        .reset          (reset),
        .FAULT_DETECTED (fd_main),
        .bist_done      (done_main)
    );

    bist_alu #(.NUM_PATTERNS(N_SHORT)) dut_short (
        .clk            (clk),
        .reset          (reset),
        .FAULT_DETECTED (fd_short),
        .bist_done      (done_short)
    );

    bist_alu_cut #(.WIDTH(8)) u_cut (.a(ua), .b(ub), .op(uop), .res(ucut));
    bist_alu_ref #(.WIDTH(8)) u_ref (.a(ua), .b(ub), .op(uop), .res(uref));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ALU function from the opcode table, in plain integer arithmetic.
    function automatic logic [8:0] model_alu(input int a, input int b,
                                             input int op);
        int r;
        case (op)
            0: r = a + b;
            1: begin r = a - b; if (r < 0) r += 512; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = a * 2;
            default: r = (a % 2) * 256 + a / 2;
        endcase
        return 9'(r);
    endfunction

    function automatic logic [15:0] poly_step(input logic [15:0] v);
        int fb;
        fb = int'(v[15]) ^ int'(v[13]) ^ int'(v[12]) ^ int'(v[10]);
        return 16'((int'(v) * 2) % 65536 + fb);
    endfunction

    // Whole-test model: final LFSR and both signatures after n patterns.
    task automatic model_bist(input int n, output logic [15:0] l_out,
                              output logic [15:0] c_out, output logic [15:0] r_out);
        logic [15:0] l, c, r;
        logic [8:0]  res, cres;
        l = LFSR_SEED;
        c = MISR_SEED;
        r = MISR_SEED;
        for (int i = 0; i < n; i++) begin
            res  = model_alu(int'(l) % 256, int'(l) / 256, i % 8);
            cres = res;
`ifdef BIST_ALU_FAULT_INJECT_EN
            cres[FAULT_BIT] = 1'b0;
`endif
            c = poly_step(c) ^ 16'(cres);
            r = poly_step(r) ^ 16'(res);
            l = poly_step(l);
        end
        l_out = l;
        c_out = c;
        r_out = r;
    endtask

    // Advance edges first_k .. first_k+count-1 (edge 0 = first edge with
    // reset high), checking both instances after each edge.
    task automatic run_edges(input int first_k, input int count);
        for (int k = first_k; k < first_k + count; k++) begin
            @(negedge clk);
            check("done_main",  32'(done_main),  32'(k >= N_MAIN + 2));
            check("fault_main", 32'(fd_main),
                  32'((k >= N_MAIN + 2) ? exp_fault_main : 1'b0));
            check("done_short",  32'(done_short), 32'(k >= N_SHORT + 2));
            check("fault_short", 32'(fd_short),
                  32'((k >= N_SHORT + 2) ? exp_fault_short : 1'b0));
        end
    endtask

    task automatic check_final(input string tag);
        check({tag, "_lfsr"},     32'(dut.lfsr),           32'(m_lfsr_main));
        check({tag, "_cut_sig"},  32'(dut.cut_misr),       32'(m_cut_main));
        check({tag, "_ref_sig"},  32'(dut.ref_misr),       32'(m_ref_main));
        check({tag, "_lfsr8"},    32'(dut_short.lfsr),     32'(m_lfsr_short));
        check({tag, "_cut_sig8"}, 32'(dut_short.cut_misr), 32'(m_cut_short));
        check({tag, "_ref_sig8"}, 32'(dut_short.ref_misr), 32'(m_ref_short));
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_done"},  32'(done_main),  32'(0));
        check({tag, "_fault"}, 32'(fd_main),    32'(0));
        check({tag, "_done8"}, 32'(done_short), 32'(0));
        check({tag, "_fault8"}, 32'(fd_short),  32'(0));
        check({tag, "_lfsr"},  32'(dut.lfsr),   32'(LFSR_SEED));
        check({tag, "_sig"},   32'(dut.cut_misr), 32'(MISR_SEED));
    endtask

    initial begin
        int abort_k;
        reset = 1'b0;
        ua = '0; ub = '0; uop = '0;

        // ---- ALU unit checks, directed ----
        ua = 8'hF0; ub = 8'h20;
        uop = 3'd0; #1; check("cut_add", 32'(ucut), 32'h110); check("ref_add", 32'(uref), 32'h110);
        uop = 3'd1; #1; check("cut_sub", 32'(ucut), 32'h0D0); check("ref_sub", 32'(uref), 32'h0D0);
        ua = 8'h10;
        #1;             check("cut_borrow", 32'(ucut), 32'h1F0); check("ref_borrow", 32'(uref), 32'h1F0);
        ua = 8'hA5;
        uop = 3'd5; #1; check("cut_not", 32'(ucut), 32'h05A); check("ref_not", 32'(uref), 32'h05A);
        uop = 3'd6; #1; check("cut_shl", 32'(ucut), 32'h14A); check("ref_shl", 32'(uref), 32'h14A);
        uop = 3'd7; #1; check("cut_shr", 32'(ucut), 32'h152); check("ref_shr", 32'(uref), 32'h152);

        // ---- ALU unit checks, random ----
        for (int i = 0; i < 48; i++) begin
            ua  = 8'($urandom);
            ub  = 8'($urandom);
            uop = 3'(i % 8);
            #1;
            check("cut_rand", 32'(ucut), 32'(model_alu(int'(ua), int'(ub), int'(uop))));
            check("ref_rand", 32'(uref), 32'(model_alu(int'(ua), int'(ub), int'(uop))));
        end

        model_bist(N_MAIN,  m_lfsr_main,  m_cut_main,  m_ref_main);
        model_bist(N_SHORT, m_lfsr_short, m_cut_short, m_ref_short);
        exp_fault_main  = (m_cut_main  != m_ref_main);
        exp_fault_short = (m_cut_short != m_ref_short);

        // ---- Uninterrupted run ----
        @(negedge clk);
        @(negedge clk);           // reset edge in between
        check_in_reset("rst1");
        reset = 1'b1;
        run_edges(0, 200);
        check_final("run1");

        // ---- Freeze in DONE for 100 more cycles ----
        run_edges(200, 100);
        check_final("frozen");

        // ---- Abort at a random cycle, then a full rerun ----
        reset   = 1'b0;
        @(negedge clk);
        check_in_reset("rst2");
        reset   = 1'b1;
        abort_k = int'($urandom_range(12, 125));
        run_edges(0, abort_k + 1);
        reset   = 1'b0;
        @(negedge clk);
        check_in_reset("abort");
        reset   = 1'b1;
        run_edges(0, 200);
        check_final("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_alu.md
Name: bist_alu

Overview:
- Self-testing 8-bit ALU.
- An on-chip LFSR drives operands into the ALU, which is the circuit under test (CUT). A 16-bit MISR compacts the CUT results. A second MISR compacts the results of an independent behavioural reference ALU.
- After a fixed number of patterns the two signatures are compared, and FAULT_DETECTED reports any mismatch.
- Top-level BIST wrapper; needs only clock and reset and runs autonomously after reset.

Parameters:
- WIDTH, 8, operand width of the ALU (A and B).
- NUM_PATTERNS, 128, number of test patterns applied in RUN; legal range 8..65535.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.
- MISR_SEED, 16'h0000, value loaded into both MISRs on reset.
- FAULT_BIT, 0, result bit forced stuck-at-0 when fault injection is compiled in.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- FAULT_DETECTED  output  1  1 = CUT signature differs from reference signature; valid once bist_done=1.
- bist_done  output  1  1 = test sequence complete; held until reset.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, lfsr=LFSR_SEED, pattern counter=0, both MISRs=MISR_SEED.
  - FAULT_DETECTED=0, bist_done=0.
  - Reset asserted mid-RUN or in DONE aborts the test and restarts from IDLE.
- LFSR:
  - 16-bit Fibonacci register, shifts left; feedback bit0 = b15^b13^b12^b10 (x^16+x^14+x^13+x^11+1).
  - Advances only in RUN.
- Pattern mapping:
  - A=lfsr[7:0], B=lfsr[15:8], op=counter[2:0].
  - op is counter-driven so every opcode is exercised equally.
- ALU result is 9 bits, {carry,result[7:0]}, purely combinational. Opcodes:
  - 0: ADD, A+B, carry = carry-out.
  - 1: SUB, A-B, carry = borrow (1 when A<B).
  - 2: AND.
  - 3: OR.
  - 4: XOR.
  - 5: NOT A.
  - 6: SHL A by 1, carry = A[7], bit0=0.
  - 7: SHR A by 1, carry = A[0], bit7=0.
  - Logic ops (2..5) drive carry=0.
- Reference ALU:
  - Separately coded behavioural model, same 9-bit function.
  - Must not share logic with the CUT; synthesis-keep attribute on both.
- MISR (each of the two):
  - 16-bit, same polynomial as the LFSR.
  - Each RUN cycle: misr <= {misr[14:0], fb} ^ {7'b0, res9}, where fb = b15^b13^b12^b10 of the current misr.
- States:
  - IDLE: exactly 1 cycle after reset release, then go to RUN.
  - RUN: each cycle, both MISRs absorb their result, the LFSR advances and the counter increments. When counter==NUM_PATTERNS-1 is absorbed, go to COMPARE.
  - COMPARE: 1 cycle; register FAULT_DETECTED <= (cut_sig != ref_sig); go to DONE.
  - DONE: bist_done=1; LFSR, MISRs and FAULT_DETECTED frozen; remain until reset.
- Timing: first rising edge with reset=1 is cycle 0.
  - RUN covers cycles 1..NUM_PATTERNS.
  - FAULT_DETECTED and bist_done become valid after edge NUM_PATTERNS+2, i.e. cycle 130 by default (≈1.3 µs at 100 MHz).
- Counter width: 16 bits; no wrap is possible within legal NUM_PATTERNS.
- FAULT_DETECTED is never asserted before COMPARE.

Optional Feature:
- Macro BIST_ALU_FAULT_INJECT_EN.
- When defined: CUT result bit FAULT_BIT is forced to 0 (stuck-at-0); the reference ALU is unaffected.
- When undefined: CUT is fault-free and FAULT_DETECTED must read 0 at DONE.

Test Plan:
- Reset held low 1 cycle, then high for 200 cycles, macro undefined -> bist_done=1 from cycle 130; FAULT_DETECTED=0 throughout.
- Same stimulus with BIST_ALU_FAULT_INJECT_EN, FAULT_BIT=0 -> FAULT_DETECTED=0 until cycle 130, then 1 and held; bist_done=1.
- Reset pulled low at cycle 60 for 1 cycle, then released -> outputs 0 during reset; sequence restarts and bist_done rises 130 cycles after re-release; same FAULT_DETECTED result as an uninterrupted run.
- Stay in DONE for 100 extra cycles -> LFSR, both signatures, FAULT_DETECTED and bist_done unchanged.
- Unit check of the ALU opcodes:
  - A=8'hF0, B=8'h20: op0 -> 9'h110; op1 -> 9'h0D0.
  - A=8'h10, B=8'h20: op1 -> 9'h1F0.
  - A=8'hA5: op5 -> 9'h05A; op6 -> 9'h14A; op7 -> 9'h152.
- NUM_PATTERNS=8 override -> bist_done asserts at cycle 10; FAULT_DETECTED=0 without the macro.
